seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, width-parametrised successor to the datapath's 8-bit combinational ALU.
- Keeps the existing 4-bit operation encoding and adds an arithmetic shift right.
- Takes the shift amount from a dedicated port instead of instruction bits.
- Runs shifts and rotates as a one-bit-per-cycle iterator with a start/busy/done handshake.
- Arithmetic and logic results are registered, with a registered zero flag and carry flag.
- Sits in the execute stage and is stalled by the controller while `busy` is high.

## Interface
- `WIDTH`, 8: operand/result width. Must be a power of two and at least 4.
- `SHAMT_W`, derived as clog2(WIDTH): shift-amount width. Not overridable.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only when not `busy`.
- `op`  in  4  operation code, captured with `start`.
- `a`, `b`  in  WIDTH  operands, captured with `start`.
- `shamt`  in  SHAMT_W  shift/rotate amount, captured with `start`.
- `cin`  in  1  carry/borrow in, captured with `start`.
- `busy`  out  1  high while a multi-cycle shift is iterating.
- `done`  out  1  one-cycle pulse: `y`, `zero` and `cout` are valid.
- `y`  out  WIDTH  result register.
- `zero`  out  1  registered flag, equal to (`y` == 0).
- `cout`  out  1  carry/borrow or shifted-out-bit flag.

## Operation
- Opcodes:
  - 0000 ADD: a+b.
  - 0001 ADC: a+b+cin.
  - 0010 SUB: a−b.
  - 0011 SBC: a−b−cin.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NAND.
  - 1000 SLL, 1001 SRL, 1010 ROL, 1011 ROR.
  - 1100 ASR (shift right, replicating the MSB).
  - 1101–1111 reserved: y=0, cout held, single cycle.
- Arithmetic width: computed at WIDTH+1 bits.
  - ADD/ADC: cout = bit WIDTH of the sum.
  - SUB/SBC: cout = borrow, i.e. 1 when a < b+cin unsigned. The result wraps modulo 2^WIDTH.
- Logic ops: `cout` is held at its previous value.
- Shifts and rotates: `cout` = the last bit shifted out.
  - ROL: `cout` = the bit moved into the LSB.
  - ROR: `cout` = the bit moved into the MSB.
  - shamt=0: y=a and `cout` is held.
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1, `busy`=0.
- Start accepted in IDLE or DONE:
  - Non-shift op, or shift with shamt ≤ 1: compute the full result into `y`, go to DONE.
  - Shift with shamt ≥ 2: load `y` = a shifted once, set count = shamt−1, go to RUN.
- RUN, each edge: shift `y` by one and decrement count. When count reaches 1 → 0 on that edge, go to DONE.
- DONE:
  - No `start`: go to IDLE. `y`, `zero` and `cout` hold until the next accepted start.
  - `start` present: accept it back-to-back.
- `start` while in RUN is ignored and is not queued.
- Operands are captured at the accepting edge. Later changes to `a`, `b`, `shamt`, `cin` or `op` do not affect the operation in flight.
- During RUN, `y` shows intermediate values. It is valid only while `done` is high, or while idle after `done`.

## Timing
- Reset values (asynchronous): state IDLE, `busy`=0, `done`=0, `y`=0, `cout`=0, `zero`=1.
- Reset asserted mid-RUN aborts the operation immediately. No `done` is issued.
- Latency, counted in rising edges from the accepting edge E0 to the cycle `done` is high:
  - Non-shift op, or shamt ≤ 1: `done` high in the cycle after E0.
  - Shift with shamt=k, k ≥ 2: `busy` high for k−1 cycles after E0, then `done` high in the cycle after edge Ek−1.
- Throughput: a new op can be accepted on the edge where `done` is high, so no bubble is needed.
- `zero` and `cout` update on the same edges as `y`.

## Test plan
- Reset, then ADD a=0xF0 b=0x20:
  - `done` is high one cycle after start.
  - y=0x10, cout=1, zero=0.
- SUB a=0x05 b=0x05 → y=0x00, zero=1, cout=0.
- SBC a=0x03 b=0x05 cin=1 → y=0xFD, cout=1.
- SLL a=0x81 shamt=3:
  - `busy` is high for 2 cycles.
  - `done` is high in the cycle after the 3rd edge.
  - y=0x08, cout=0.
- Toggle `a` and assert `start` (with a different `op`) during the SLL's RUN → no effect on the result and no extra `done`.
- ROR a=0x01 shamt=1 → single-cycle `done`, y=0x80, cout=1.
- ASR a=0x90 shamt=2 → y=0xE4, cout=0.
- SRL with shamt=0 → y=a in one cycle, cout unchanged.
- Start ROL a=0xFF shamt=7, then assert `rst` for one cycle after 3 edges:
  - Immediately `busy`=0, `done`=0, y=0, zero=1, cout=0.
  - No `done` pulse follows.
- Back-to-back: start ADD, and assert a new `start` (XOR a=0xAA b=0xAA) in its `done` cycle:
  - `done` stays high for a second consecutive cycle.
  - y=0x00, zero=1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle, width-parametrised ALU for the execute stage.
//
// Add/sub and logic ops finish in one cycle. Shifts and rotates move one bit
// per cycle, and the controller stalls the pipe while busy is high.
// Results and flags are registered.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            request, sampled only when not busy
//   op[3:0]          operation code, captured with start
//   a, b [WIDTH]     operands, captured with start
//   shamt [SHAMT_W]  shift/rotate amount, captured with start
//   cin              carry/borrow in, captured with start
//   busy             shift iterating
//   done             one-cycle pulse: y/zero/cout valid
//   y [WIDTH]        result register
//   zero             registered (y == 0)
//   cout             carry/borrow or last shifted-out bit
module seq_alu #(
    parameter int  WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic               cout
);

    localparam logic [3:0] op_add  = 4'b0000;
    localparam logic [3:0] op_adc  = 4'b0001;
    localparam logic [3:0] op_sub  = 4'b0010;
    localparam logic [3:0] op_sbc  = 4'b0011;
    localparam logic [3:0] op_and  = 4'b0100;
    localparam logic [3:0] op_or   = 4'b0101;
    localparam logic [3:0] op_xor  = 4'b0110;
    localparam logic [3:0] op_nand = 4'b0111;
    localparam logic [3:0] op_sll  = 4'b1000;
    localparam logic [3:0] op_srl  = 4'b1001;
    localparam logic [3:0] op_rol  = 4'b1010;
    localparam logic [3:0] op_ror  = 4'b1011;
    localparam logic [3:0] op_asr  = 4'b1100;

    localparam logic [SHAMT_W-1:0] cnt_one = SHAMT_W'(1);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic [3:0]         op_r, op_nxt;
    logic [WIDTH-1:0]   y_nxt;
    logic               cout_nxt;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH:0]     step_a, step_run;

    // One shift/rotate step. Returns {bit shifted out, shifted value}.
    // For rotates the "shifted-out" bit is the one that wraps around.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] o,
                                                  input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        r = {1'b0, v};
        case (o)
            op_sll:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            op_srl:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            op_rol:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            op_ror:  r = {v[0], v[0], v[WIDTH-1:1]};
            op_asr:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    // Shift group is 1000..1100; 1101..1111 are reserved.
    function automatic logic is_shift(input logic [3:0] o);
        return o[3] && (o[2:0] <= 3'd4);
    endfunction

    // WIDTH+1 bit arithmetic: bit WIDTH is the carry for add and, because the
    // subtraction wraps negative, the borrow for sub.
    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == op_adc) & cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == op_sbc) & cin};

    assign step_a   = shift_step(op, a);
    assign step_run = shift_step(op_r, y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_idle;
            y     <= '0;
            zero  <= 1'b1;
            cout  <= 1'b0;
            cnt   <= '0;
            op_r  <= '0;
        end else begin
            state <= state_nxt;
            y     <= y_nxt;
            zero  <= (y_nxt == '0);
            cout  <= cout_nxt;
            cnt   <= cnt_nxt;
            op_r  <= op_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        y_nxt     = y;
        cout_nxt  = cout;
        cnt_nxt   = cnt;
        op_nxt    = op_r;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            st_run: begin
                // start is ignored here; nothing is queued.
                busy     = 1'b1;
                y_nxt    = step_run[WIDTH-1:0];
                cout_nxt = step_run[WIDTH];
                cnt_nxt  = cnt - cnt_one;
                if (cnt == cnt_one)
                    state_nxt = st_done;
            end
            default: begin
                // IDLE and DONE both accept, so DONE allows back-to-back ops.
                done = (state == st_done);
                if (!start) begin
                    state_nxt = st_idle;
                end else begin
                    op_nxt    = op;
                    state_nxt = st_done;
                    case (op)
                        op_add, op_adc: {cout_nxt, y_nxt} = sum;
                        op_sub, op_sbc: {cout_nxt, y_nxt} = diff;
                        op_and:         y_nxt = a & b;
                        op_or:          y_nxt = a | b;
                        op_xor:         y_nxt = a ^ b;
                        op_nand:        y_nxt = ~(a & b);
                        default: begin
                            if (is_shift(op)) begin
                                if (shamt == '0) begin
                                    y_nxt = a;          // cout held
                                end else begin
                                    y_nxt    = step_a[WIDTH-1:0];
                                    cout_nxt = step_a[WIDTH];
                                    if (shamt != cnt_one) begin
                                        // First step done now; shamt-1 remain.
                                        cnt_nxt   = shamt - cnt_one;
                                        state_nxt = st_run;
                                    end
                                end
                            end else begin
                                y_nxt = '0;             // reserved, cout held
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [2:0] shamt;
    logic       cin;
    logic       busy, done, zero, cout;
    logic [7:0] y;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .shamt(shamt), .cin(cin), .busy(busy), .done(done), .y(y),
        .zero(zero), .cout(cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sh;
        logic       cin;
        logic [7:0] ey;
        logic       ec;
        logic       ez;
        int         lat;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Start at the next negedge, then count cycles (sampled on negedges) until done.
    task automatic run_vec(input vec_t v, input string nm);
        int n;
        int nbusy;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; shamt = v.sh; cin = v.cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'h00; b = 8'h00; op = 4'hF; shamt = 3'd0; cin = 1'b0;
        n = 1;
        nbusy = 0;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"},  n, v.lat);
        chk({nm, "_busy"}, nbusy, v.lat - 1);
        chk({nm, "_y"},    int'(y), int'(v.ey));
        chk({nm, "_cout"}, int'(cout), int'(v.ec));
        chk({nm, "_zero"}, int'(zero), int'(v.ez));
        @(negedge clk);
        chk({nm, "_pulse"}, int'(done), 0);
    endtask

    initial begin
        //            op     a      b      sh    cin   ey     ec    ez    lat
        vt[0]  = '{4'h0, 8'hF0, 8'h20, 3'd0, 1'b0, 8'h10, 1'b1, 1'b0, 1}; // ADD carry
        vt[1]  = '{4'h2, 8'h05, 8'h05, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1}; // SUB ignores cin
        vt[2]  = '{4'h3, 8'h03, 8'h05, 3'd0, 1'b1, 8'hFD, 1'b1, 1'b0, 1}; // SBC borrow
        vt[3]  = '{4'h4, 8'hF0, 8'h3C, 3'd0, 1'b0, 8'h30, 1'b1, 1'b0, 1}; // AND, cout held
        vt[4]  = '{4'h5, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1}; // OR
        vt[5]  = '{4'h6, 8'hAA, 8'h55, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0, 1}; // XOR
        vt[6]  = '{4'h7, 8'hFF, 8'hFF, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1}; // NAND
        vt[7]  = '{4'h1, 8'hFF, 8'h00, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1}; // ADC
        vt[8]  = '{4'h8, 8'h81, 8'h00, 3'd3, 1'b0, 8'h08, 1'b0, 1'b0, 3}; // SLL 3
        vt[9]  = '{4'hB, 8'h01, 8'h00, 3'd1, 1'b0, 8'h80, 1'b1, 1'b0, 1}; // ROR 1
        vt[10] = '{4'hC, 8'h90, 8'h00, 3'd2, 1'b0, 8'hE4, 1'b0, 1'b0, 2}; // ASR 2
        vt[11] = '{4'h0, 8'hFF, 8'h01, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1}; // ADD ignores cin
        vt[12] = '{4'h9, 8'h5A, 8'h00, 3'd0, 1'b0, 8'h5A, 1'b1, 1'b0, 1}; // SRL 0, cout held
        vt[13] = '{4'hA, 8'h81, 8'h00, 3'd4, 1'b0, 8'h18, 1'b0, 1'b0, 4}; // ROL 4
        vt[14] = '{4'h9, 8'h81, 8'h00, 3'd7, 1'b0, 8'h01, 1'b0, 1'b0, 7}; // SRL 7
        vt[15] = '{4'h8, 8'h80, 8'h00, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1}; // SLL 1
        vt[16] = '{4'hE, 8'hFF, 8'hFF, 3'd5, 1'b0, 8'h00, 1'b1, 1'b1, 1}; // reserved
        vt[17] = '{4'h2, 8'h00, 8'h01, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0, 1}; // SUB wrap
        vt[18] = '{4'hC, 8'h80, 8'h00, 3'd7, 1'b0, 8'hFF, 1'b0, 1'b0, 7}; // ASR 7
        vt[19] = '{4'hB, 8'h06, 8'h00, 3'd3, 1'b0, 8'hC0, 1'b1, 1'b0, 3}; // ROR 3

        rst = 1'b1; start = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00;
        shamt = 3'd0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y",    int'(y), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_cout", int'(cout), 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            run_vec(vt[i], $sformatf("v%0d", i));

        // SLL 0x81 by 3 with a competing start and operand churn during RUN.
        begin
            int ndone;
            @(negedge clk);
            op = 4'h8; a = 8'h81; b = 8'h00; shamt = 3'd3; start = 1'b1;
            @(negedge clk);                          // after E0
            chk("dist_busy1", int'(busy), 1);
            a = 8'hFF; b = 8'h01; op = 4'h0; shamt = 3'd1; // start still high
            @(negedge clk);                          // after E1
            chk("dist_busy2", int'(busy), 1);
            start = 1'b0;
            @(negedge clk);                          // after E2
            chk("dist_done", int'(done), 1);
            chk("dist_y",    int'(y), 8'h08);
            chk("dist_cout", int'(cout), 0);
            ndone = 0;
            repeat (5) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("dist_extra_done", ndone, 0);
        end

        // Reset mid-RUN: ROL 0xFF by 7, reset after three edges.
        begin
            int ndone;
            @(negedge clk);
            op = 4'hA; a = 8'hFF; shamt = 3'd7; start = 1'b1;
            @(negedge clk);                          // after E0
            start = 1'b0;
            repeat (2) @(negedge clk);               // after E2
            chk("abort_busy_pre", int'(busy), 1);
            chk("abort_cout_pre", int'(cout), 1);
            rst = 1'b1;
            #1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            chk("abort_y",    int'(y), 0);
            chk("abort_zero", int'(zero), 1);
            chk("abort_cout", int'(cout), 0);
            @(negedge clk);
            rst = 1'b0;
            ndone = 0;
            repeat (10) begin
                @(negedge clk);
                if (done || busy) ndone++;
            end
            chk("abort_no_done", ndone, 0);
        end

        // Back-to-back: ADD then XOR accepted in the ADD's done cycle.
        @(negedge clk);
        op = 4'h0; a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("b2b_done1", int'(done), 1);
        chk("b2b_y1",    int'(y), 8'h03);
        op = 4'h6; a = 8'hAA; b = 8'hAA;             // start stays high
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", int'(done), 1);
        chk("b2b_y2",    int'(y), 8'h00);
        chk("b2b_zero2", int'(zero), 1);
        @(negedge clk);
        chk("b2b_idle",  int'(done), 0);
        chk("b2b_hold",  int'(y), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
